// File: rtl/ack_burst_responder.sv
// Responder side of the transmit/receive/complete handshake: after a fixed
// lead it issues a clamped burst of single-cycle acknowledges, then completes.
module ack_burst_responder #(
   parameter int MIN_BEATS = 2,
   parameter int MAX_BEATS = 5,
   parameter int LEAD      = 2,
   parameter int MAX_GAP   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmiter,
   input  logic [2:0] num_beats,
   input  logic [1:0] gap,
   output logic       recevier,
   output logic       complete,
   output logic       busy,
   output logic       overrun
);

   localparam int GW = $clog2(MAX_GAP + 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_S,
      BEAT,
      GAP,
      DONE
   } state_t;

   state_t        state;
   logic [2:0]    beats_q;
   logic [2:0]    cnt;
   logic [GW-1:0] gap_q;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    lead_cnt;

   function automatic logic [2:0] clamp(input logic [2:0] n);
      if (n < 3'(MIN_BEATS))
         return 3'(MIN_BEATS);
      else if (n > 3'(MAX_BEATS))
         return 3'(MAX_BEATS);
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         recevier <= 1'b0;
         complete <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         beats_q  <= 3'd0;
         cnt      <= 3'd0;
         gap_q    <= '0;
         gap_cnt  <= '0;
         lead_cnt <= 4'd0;
      end else begin
         // any request outside IDLE, including the complete cycle, is dropped
         if (transmiter && state != IDLE)
            overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (transmiter) begin
                  beats_q  <= clamp(num_beats);
                  gap_q    <= GW'(gap);
                  cnt      <= 3'd0;
                  lead_cnt <= 4'(LEAD - 2);
                  busy     <= 1'b1;
                  state    <= LEAD_S;
               end
            end
            LEAD_S: begin
               if (lead_cnt == 4'd0) begin
                  recevier <= 1'b1;
                  cnt      <= 3'd1;
                  state    <= BEAT;
               end else begin
                  lead_cnt <= lead_cnt - 4'd1;
               end
            end
            BEAT: begin
               recevier <= 1'b0;
               if (cnt == beats_q) begin
                  complete <= 1'b1;
                  state    <= DONE;
               end else if (gap_q != '0) begin
                  gap_cnt <= gap_q;
                  state   <= GAP;
               end else begin
                  recevier <= 1'b1;
                  cnt      <= cnt + 3'd1;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(1)) begin
                  recevier <= 1'b1;
                  cnt      <= cnt + 3'd1;
                  state    <= BEAT;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end
            DONE: begin
               complete <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ack_burst_responder.sv
// Scoreboard bench: a cycle-schedule reference model predicts acknowledge and
// completion cycles; a monitor pops and compares as the DUT pulses.
module tb_ack_burst_responder;

   localparam int NC = 3000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       transmiter = 1'b0;
   logic [2:0] num_beats = 3'd0;
   logic [1:0] gap = 2'd0;
   logic       recevier;
   logic       complete;
   logic       busy;
   logic       overrun;

   int tests = 0;
   int fails = 0;

   int rq[$];
   int cq[$];
   bit eb[0:NC+2];
   bit eo[0:NC+2];
   int end_c = -1;
   bit ov_m = 1'b0;

   ack_burst_responder dut (
      .clk(clk),
      .rst(rst),
      .transmiter(transmiter),
      .num_beats(num_beats),
      .gap(gap),
      .recevier(recevier),
      .complete(complete),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Expected schedule from inputs sampled at cycle n.
   task automatic model(input int n);
      int b;
      int g;
      int c;
      if (rst) begin
         end_c = n;
         ov_m = 1'b0;
         rq = rq.find(x) with (x <= n);
         cq = cq.find(x) with (x <= n);
      end else if (transmiter) begin
         if (n > end_c) begin
            b = int'(num_beats);
            if (b < 2) b = 2;
            if (b > 5) b = 5;
            g = int'(gap);
            for (int k = 0; k < b; k++)
               rq.push_back(n + 2 + k * (g + 1));
            c = n + 2 + (b - 1) * (g + 1) + 1;
            cq.push_back(c);
            end_c = c;
         end else begin
            ov_m = 1'b1;
         end
      end
      eb[n+1] = !rst && (n + 1 <= end_c);
      eo[n+1] = ov_m;
   endtask

   task automatic drive(input int n);
      rst = 1'b0;
      transmiter = 1'b0;
      if (n < 110) begin
         case (n)
            0, 1: rst = 1'b1;
            3:  begin transmiter = 1'b1; num_beats = 3'd2; gap = 2'd0; end
            10: begin transmiter = 1'b1; num_beats = 3'd5; gap = 2'd1; end
            30: begin transmiter = 1'b1; num_beats = 3'd0; gap = 2'd2; end
            40: begin transmiter = 1'b1; num_beats = 3'd7; gap = 2'd0; end
            70: begin transmiter = 1'b1; num_beats = 3'd4; gap = 2'd1; end
            72: begin num_beats = 3'd2; gap = 2'd0; end
            90: begin transmiter = 1'b1; num_beats = 3'd5; gap = 2'd3; end
            95: rst = 1'b1;
            97: transmiter = 1'b1;
            default: ;
         endcase
         if (n >= 50 && n <= 56) begin
            transmiter = 1'b1;
            num_beats = 3'd3;
            gap = 2'd0;
         end
      end else if (n < NC - 40) begin
         transmiter = ($urandom % 4) == 0;
         num_beats = 3'($urandom % 8);
         gap = 2'($urandom % 4);
         rst = ($urandom % 150) == 0;
      end
   endtask

   initial begin
      for (int n = 0; n < NC; n++) begin
         drive(n);
         model(n);
         @(posedge clk);
         #1;
      end
      #10;
      tests++;
      if (rq.size() != 0) begin
         fails++;
         $display("FAIL leftover_ack: got %0d pending, want 0 (first %0d)",
                  rq.size(), rq[0]);
      end
      tests++;
      if (cq.size() != 0) begin
         fails++;
         $display("FAIL leftover_complete: got %0d pending, want 0 (first %0d)",
                  cq.size(), cq[0]);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Monitor: value seen after edge e is the output "at cycle e+1".
   initial begin
      int e;
      int k;
      e = 0;
      forever begin
         @(posedge clk);
         #2;
         k = e + 1;
         if (k >= 2 && k <= NC) begin
            while (rq.size() != 0 && rq[0] < k) begin
               tests++;
               fails++;
               $display("FAIL missing_ack: cycle %0d got none, want ack", rq[0]);
               void'(rq.pop_front());
            end
            while (cq.size() != 0 && cq[0] < k) begin
               tests++;
               fails++;
               $display("FAIL missing_complete: cycle %0d got none, want pulse", cq[0]);
               void'(cq.pop_front());
            end
            if (recevier !== 1'b0) begin
               tests++;
               if (rq.size() != 0 && rq[0] == k) begin
                  void'(rq.pop_front());
               end else begin
                  fails++;
                  $display("FAIL extra_ack: cycle %0d got %b, want 0", k, recevier);
               end
            end
            if (complete !== 1'b0) begin
               tests++;
               if (cq.size() != 0 && cq[0] == k) begin
                  void'(cq.pop_front());
               end else begin
                  fails++;
                  $display("FAIL extra_complete: cycle %0d got %b, want 0", k, complete);
               end
            end
            tests++;
            if (recevier === 1'b1 && complete === 1'b1) begin
               fails++;
               $display("FAIL ack_and_complete: cycle %0d got both 1, want exclusive", k);
            end
            tests++;
            if (busy !== eb[k]) begin
               fails++;
               $display("FAIL busy: cycle %0d got %b, want %b", k, busy, eb[k]);
            end
            tests++;
            if (overrun !== eo[k]) begin
               fails++;
               $display("FAIL overrun: cycle %0d got %b, want %b", k, overrun, eo[k]);
            end
         end
         e++;
      end
   end

endmodule
